fetch_unit: RTL

Instruction-fetch front end of the five-stage pipeline. It owns the PC register, drives the instruction bus, and produces `imem_wait` for the hazard unit. It also consumes the hazard unit's `PCWrite` code and the branch redirect `PCSel`/`pc_target`. It keeps the bus legal when a redirect arrives while a fetch is in flight: the request is never aborted, the stale response is discarded, and the pending target is issued afterwards.

---
 rtl/fetch_unit.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch front end of the five-stage pipeline. Owns the PC, drives
// the instruction bus and tells the hazard unit when fetch is not ready.
//
// A request on the bus is never aborted. When a redirect arrives while a fetch
// is outstanding, the target is parked in a pending register, the wrong-path
// response is swallowed, and the target is fetched afterwards.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high
//   PCWrite[1:0]   hazard code: 00 advance, 01/11 hold (ignored while waiting)
//   PCSel          redirect request from execute
//   pc_target      redirect address, sampled when PCSel=1
//   ireq_valid     instruction request valid
//   ireq_addr      request address
//   iresp_data_ok  response for the outstanding request
//   iresp_data     instruction word, valid with iresp_data_ok
//   pc             address of the instruction presented on instr
//   instr          fetched instruction
//   instr_valid    instr is a correct-path instruction
//   imem_wait      fetch not ready (to the hazard unit)
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [63:0] PC_RESET = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  PCWrite,
  input  logic        PCSel,
  input  logic [63:0] pc_target,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic [63:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        imem_wait
);

  // FETCH   : request on the bus for pc_q
  // HOLD    : response captured, pipeline stalled, bus idle
  // DISCARD : redirect seen mid-request; waiting out the stale response
  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic        buf_stale_q, buf_stale_d;
  logic        pend_valid_q, pend_valid_d;
  logic [63:0] pend_pc_q, pend_pc_d;

  // Unreset-gated versions of the outputs; reset forcing is applied at the end.
  logic        ireq_valid_int;
  logic        imem_wait_int;
  logic [31:0] instr_int;
  logic        instr_valid_int;
  logic        advance;
  logic [63:0] pc_seq;

  assign pc_seq = pc_q + 64'd4;

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    buf_instr_d     = buf_instr_q;
    buf_stale_d     = buf_stale_q;
    pend_valid_d    = pend_valid_q;
    pend_pc_d       = pend_pc_q;
    ireq_valid_int  = 1'b0;
    imem_wait_int   = 1'b1;
    instr_int       = 32'h0;
    instr_valid_int = 1'b0;
    advance         = 1'b0;

    // Output decode first: advance depends on imem_wait.
    case (state_q)
      S_FETCH: begin
        ireq_valid_int  = 1'b1;
        imem_wait_int   = !iresp_data_ok;
        instr_int       = iresp_data;
        instr_valid_int = iresp_data_ok && !pend_valid_q;
      end
      S_HOLD: begin
        ireq_valid_int  = 1'b0;
        imem_wait_int   = 1'b0;
        instr_int       = buf_instr_q;
        instr_valid_int = !(buf_stale_q || pend_valid_q);
      end
      S_DISCARD: begin
        ireq_valid_int  = 1'b1;
        imem_wait_int   = 1'b1;
        instr_int       = 32'h0;
        instr_valid_int = 1'b0;
      end
      default: begin
        ireq_valid_int  = 1'b0;
        imem_wait_int   = 1'b1;
      end
    endcase

    // Only 00 advances; every other code holds. PCWrite is meaningless
    // while waiting, so the wait term masks it.
    advance = (PCWrite == 2'b00) && !imem_wait_int;

    if (advance) begin
      // A same-cycle redirect wins over an older pending one.
      if (PCSel)             pc_d = pc_target;
      else if (pend_valid_q) pc_d = pend_pc_q;
      else                   pc_d = pc_seq;
      pend_valid_d = 1'b0;
      state_d      = S_FETCH;
    end else if ((state_q == S_DISCARD) && iresp_data_ok) begin
      // Stale response retires; jump to the newest redirect target.
      pc_d         = PCSel ? pc_target : pend_pc_q;
      pend_valid_d = 1'b0;
      state_d      = S_FETCH;
    end else begin
      if (PCSel) begin
        pend_valid_d = 1'b1;
        pend_pc_d    = pc_target;
      end
      case (state_q)
        S_FETCH: begin
          if (iresp_data_ok) begin
            buf_instr_d = iresp_data;
            buf_stale_d = pend_valid_q || PCSel;
            state_d     = S_HOLD;
          end else if (PCSel) begin
            // The request cannot be withdrawn, so ride it out in DISCARD
            // with ireq_addr held stable.
            state_d = S_DISCARD;
          end
        end
        S_HOLD: begin
          if (PCSel) buf_stale_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_FETCH;
      pc_q         <= PC_RESET;
      buf_instr_q  <= 32'h0;
      buf_stale_q  <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= 64'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      buf_instr_q  <= buf_instr_d;
      buf_stale_q  <= buf_stale_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

  // Reset forces the bus idle immediately, abandoning any in-flight request.
  assign ireq_valid  = !reset && ireq_valid_int;
  assign imem_wait   = reset || imem_wait_int;
  assign instr       = reset ? 32'h0 : instr_int;
  assign instr_valid = !reset && instr_valid_int;
  assign ireq_addr   = pc_q;
  assign pc          = pc_q;

endmodule
